// File: rtl/vga_line_fetch.sv
// ----------------------------------------------------------------------------
// vga_line_fetch
//
// Downstream stage of the 800x600 VGA timing generator. While the system is in
// state 8'h03 it double-buffers one 400x300 RGB565 image row at a time from the
// SPRAM image store and emits 2x-scaled pixels (each image pixel covers 2x2
// screen pixels). HS/VS are re-registered so colour and sync stay aligned.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   state             system state; the block operates only in 8'h03
//   xpos, ypos        timing generator coordinates (active 0..799 / 0..599)
//   spram_rd_sig      one-cycle pulse at the end of each line's active region
//   hs_in, vs_in      sync from the timing generator (negative polarity)
//   mem_rd_en         SPRAM read enable
//   mem_addr          SPRAM word address
//   mem_rdata         SPRAM read data, valid RD_LAT cycles after mem_rd_en
//   vga_r/g/b         pixel colour, 2 cycles after (xpos, ypos)
//   vga_hs, vga_vs    hs_in/vs_in delayed 2 cycles
//   fetch_busy        fetch FSM not idle
//   underrun          sticky: a buffer swap arrived while a fetch was running
// ----------------------------------------------------------------------------
module vga_line_fetch #(
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 300,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        state,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    input  logic              spram_rd_sig,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [4:0]        vga_r,
    output logic [5:0]        vga_g,
    output logic [4:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              fetch_busy,
    output logic              underrun
);

    localparam int IDX_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } fetch_state_e;

    // ------------------------------------------------------------------
    // Fetch side state
    // ------------------------------------------------------------------
    fetch_state_e      fsm_q, fsm_d;
    logic [IDX_W-1:0]  rd_i_q, rd_i_d;
    logic [2:0]        drain_cnt_q, drain_cnt_d;
    logic [ROW_W-1:0]  row_n_q, row_n_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              wb_q, wb_d;
    logic              underrun_q, underrun_d;

    // Per-issue tracking of which buffer slot each returning word belongs to.
    logic [RD_LAT-1:0] wr_vld_q, wr_vld_d;
    logic [IDX_W-1:0]  wr_idx_q [RD_LAT];
    logic [IDX_W-1:0]  wr_idx_d [RD_LAT];

    logic              op;
    logic              sched_start;
    logic              sched_swap;
    logic              busy;
    logic              fetch_done_now;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;

    assign op             = (state == 8'h03);
    assign sched_start    = op && spram_rd_sig && (ypos == 10'd1021);
    assign sched_swap     = op && spram_rd_sig &&
                            ((ypos == 10'd1023) || (ypos[0] && (ypos <= 10'd597)));
    assign busy           = (fsm_q != ST_IDLE);
    assign fetch_done_now = (fsm_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST);
    assign wr_en          = wr_vld_q[RD_LAT-1];
    assign wr_addr        = wr_idx_q[RD_LAT-1];

    always_comb begin
        fsm_d       = fsm_q;
        rd_i_d      = rd_i_q;
        drain_cnt_d = drain_cnt_q;
        row_n_d     = row_n_q;
        row_base_d  = row_base_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = mem_rd_en_q;
        wb_d        = wb_q;
        underrun_d  = underrun_q;

        // Return-tracking pipeline: stage 0 tags the word issued this cycle.
        wr_vld_d    = wr_vld_q;
        wr_idx_d    = wr_idx_q;
        wr_vld_d[0] = mem_rd_en_q;
        wr_idx_d[0] = rd_i_q;
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            wr_vld_d[k] = wr_vld_q[k-1];
            wr_idx_d[k] = wr_idx_q[k-1];
        end

        case (fsm_q)
            ST_IDLE: ;
            ST_READ: begin
                if (rd_i_q == IDX_LAST) begin
                    fsm_d       = ST_DRAIN;
                    drain_cnt_d = '0;
                    mem_rd_en_d = 1'b0;
                end else begin
                    rd_i_d     = rd_i_q + 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    fsm_d = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        if (!op) begin
            fsm_d       = ST_IDLE;
            mem_rd_en_d = 1'b0;
            wb_d        = 1'b0;
            wr_vld_d    = '0;
        end else if (sched_start) begin
            row_n_d     = '0;
            row_base_d  = '0;
            fsm_d       = ST_READ;
            rd_i_d      = '0;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = '0;
            wr_vld_d    = '0;
        end else if (sched_swap) begin
            // A word landing on this very edge is written to the old write
            // buffer (wb_q); only words still in the return pipeline are
            // dropped. A swap on the final drain cycle is therefore a
            // completed fetch, not an underrun.
            if (busy && !fetch_done_now) begin
                underrun_d = 1'b1;
            end
            wb_d        = ~wb_q;
            wr_vld_d    = '0;
            fsm_d       = ST_IDLE;
            mem_rd_en_d = 1'b0;
            if (row_n_q != ROW_LAST) begin
                row_n_d     = row_n_q + 1'b1;
                row_base_d  = row_base_q + ROW_STRIDE;
                fsm_d       = ST_READ;
                rd_i_d      = '0;
                mem_rd_en_d = 1'b1;
                mem_addr_d  = row_base_q + ROW_STRIDE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            rd_i_q      <= '0;
            drain_cnt_q <= '0;
            row_n_q     <= '0;
            row_base_q  <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            wb_q        <= 1'b0;
            underrun_q  <= 1'b0;
            wr_vld_q    <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                wr_idx_q[k] <= '0;
            end
        end else begin
            fsm_q       <= fsm_d;
            rd_i_q      <= rd_i_d;
            drain_cnt_q <= drain_cnt_d;
            row_n_q     <= row_n_d;
            row_base_q  <= row_base_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            wb_q        <= wb_d;
            underrun_q  <= underrun_d;
            wr_vld_q    <= wr_vld_d;
            wr_idx_q    <= wr_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and display pipeline
    // ------------------------------------------------------------------
    logic [15:0]      buf0_mem [IMG_W];
    logic [15:0]      buf1_mem [IMG_W];
    logic [15:0]      pix_q;
    logic [8:0]       rd_idx_raw;
    logic [IDX_W-1:0] rd_idx;

    logic             active_q, active_d;
    logic             hs1_q, vs1_q;
    logic             hs2_q, vs2_q;
    logic [15:0]      rgb_q, rgb_d;

    always_comb begin
        rd_idx_raw = xpos[9:1];
        // Blanking x values map past the row end; park the read on slot 0.
        rd_idx     = (int'(rd_idx_raw) < IMG_W) ? IDX_W'(rd_idx_raw) : '0;
        active_d   = op && (xpos < 10'd800) && (ypos < 10'd600);
        rgb_d      = active_q ? pix_q : '0;
    end

    // Display buffer is the one not being written: wb_q == 1 shows buf0.
    always_ff @(posedge clk) begin
        if (wr_en && !wb_q) begin
            buf0_mem[wr_addr] <= mem_rdata;
        end
        if (wr_en && wb_q) begin
            buf1_mem[wr_addr] <= mem_rdata;
        end
        pix_q <= wb_q ? buf0_mem[rd_idx] : buf1_mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            rgb_q    <= '0;
        end else begin
            active_q <= active_d;
            hs1_q    <= hs_in;
            vs1_q    <= vs_in;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            rgb_q    <= rgb_d;
        end
    end

    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign vga_r      = rgb_q[15:11];
    assign vga_g      = rgb_q[10:5];
    assign vga_b      = rgb_q[4:0];
    assign vga_hs     = hs2_q;
    assign vga_vs     = vs2_q;
    assign fetch_busy = busy;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// ----------------------------------------------------------------------------
// tb_vga_line_fetch
//
// Directed bench for vga_line_fetch. An SPRAM model returns word k = k[15:0]
// two cycles after each read. Scheduling pulses and display coordinates are
// driven directly rather than through a full timing generator.
// ----------------------------------------------------------------------------
module tb_vga_line_fetch;

    localparam int IMG_W  = 400;
    localparam int IMG_H  = 300;
    localparam int ADDR_W = 17;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        state;
    logic [9:0]        xpos;
    logic [9:0]        ypos;
    logic              spram_rd_sig;
    logic              hs_in;
    logic              vs_in;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [4:0]        vga_r;
    logic [5:0]        vga_g;
    logic [4:0]        vga_b;
    logic              vga_hs;
    logic              vga_vs;
    logic              fetch_busy;
    logic              underrun;

    int checks   = 0;
    int failures = 0;

    vga_line_fetch #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .xpos        (xpos),
        .ypos        (ypos),
        .spram_rd_sig(spram_rd_sig),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .fetch_busy  (fetch_busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // SPRAM model, two-cycle latency; poison value when no read was issued.
    logic              p1_en = 1'b0;
    logic              p2_en = 1'b0;
    logic [ADDR_W-1:0] p1_a  = '0;
    logic [ADDR_W-1:0] p2_a  = '0;

    always @(posedge clk) begin
        p1_en <= mem_rd_en;
        p1_a  <= mem_addr;
        p2_en <= p1_en;
        p2_a  <= p1_a;
    end

    assign mem_rdata = p2_en ? p2_a[15:0] : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_pix(input int x, input int y, input int base);
        logic [31:0] v;
        if (state !== 8'h03 || x >= 800 || y >= 600) return 16'h0000;
        v = base + x / 2;
        return v[15:0];
    endfunction

    // Scheduling pulse; returns in the cycle after the pulse.
    task automatic pulse(input int y);
        xpos         = 10'd984;
        ypos         = 10'(y);
        spram_rd_sig = 1'b1;
        tick();
        spram_rd_sig = 1'b0;
    endtask

    // Entered on the first fetch cycle; follows the whole fetch to idle.
    task automatic verify_fetch(input string tag, input int base);
        int errs = 0;
        check({tag, "_a0"}, mem_addr, base);
        check({tag, "_en0"}, mem_rd_en, 1);
        for (int k = 0; k < IMG_W; k++) begin
            if (mem_rd_en !== 1'b1 || mem_addr !== ADDR_W'(base + k) || fetch_busy !== 1'b1)
                errs++;
            tick();
        end
        for (int k = 0; k < RD_LAT; k++) begin
            if (mem_rd_en !== 1'b0 || fetch_busy !== 1'b1) errs++;
            tick();
        end
        if (fetch_busy !== 1'b0) errs++;
        check({tag, "_seq"}, errs, 0);
    endtask

    // Streams cnt consecutive pixels of line y; colour and sync checked 2 cycles later.
    task automatic stream(input string tag, input int y, input int x0, input int cnt, input int base);
        logic [15:0] ex [64];
        logic        eh [64];
        logic        ev [64];
        for (int j = 0; j <= cnt; j++) begin
            if (j < cnt) begin
                spram_rd_sig = 1'b0;
                xpos  = 10'(x0 + j);
                ypos  = 10'(y);
                hs_in = ((j % 3) != 0);
                vs_in = ((j % 2) != 0);
                ex[j] = exp_pix(x0 + j, y, base);
                eh[j] = hs_in;
                ev[j] = vs_in;
            end
            tick();
            if (j >= 1) begin
                check($sformatf("%s_rgb_x%0d", tag, x0 + j - 1), {vga_r, vga_g, vga_b}, ex[j-1]);
                check($sformatf("%s_hs_x%0d", tag, x0 + j - 1), vga_hs, eh[j-1]);
                check($sformatf("%s_vs_x%0d", tag, x0 + j - 1), vga_vs, ev[j-1]);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_en"}, mem_rd_en, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        check({tag, "_hs"}, vga_hs, 1);
        check({tag, "_vs"}, vga_vs, 1);
        check({tag, "_busy"}, fetch_busy, 0);
        check({tag, "_ur"}, underrun, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        state        = 8'h03;
        xpos         = '0;
        ypos         = '0;
        spram_rd_sig = 1'b0;
        hs_in        = 1'b0;
        vs_in        = 1'b0;
        repeat (3) tick();
        check_reset("rst0");
        rst = 1'b0;
        tick();

        // Frame start: row 0 into buf0, then swap and row 1.
        pulse(1021);
        verify_fetch("row0", 0);
        pulse(1023);
        verify_fetch("row1", 400);
        stream("l0", 0, 0, 6, 0);
        stream("l1", 1, 0, 4, 0);
        stream("l0e", 0, 796, 8, 0);

        // Row advance.
        pulse(1);
        verify_fetch("row2", 800);
        stream("l2", 2, 0, 4, 400);
        stream("l3e", 3, 796, 8, 400);

        // Underrun: swap 100 cycles into the row 3 fetch.
        pulse(3);
        check("ur_a0", mem_addr, 1200);
        repeat (100) tick();
        check("ur_pre", underrun, 0);
        pulse(5);
        check("ur_set", underrun, 1);
        verify_fetch("row4", 1600);
        check("ur_sticky", underrun, 1);
        stream("ur_new", 6, 194, 2, 1200);
        stream("ur_old", 6, 198, 2, 400);

        // Skip ahead to the bottom of the frame.
        for (int y = 7; y <= 593; y += 2) pulse(y);
        pulse(595);
        verify_fetch("row299", 119600);
        pulse(597);
        check("y597_en", mem_rd_en, 0);
        check("y597_busy", fetch_busy, 0);
        stream("l598", 598, 0, 4, 119600);
        stream("l598e", 598, 796, 8, 119600);
        pulse(599);
        check("y599_en", mem_rd_en, 0);
        check("y599_busy", fetch_busy, 0);
        stream("l599", 599, 0, 4, 119600);
        stream("y600", 600, 0, 4, 0);
        stream("y1000", 1000, 10, 4, 0);

        // Outside state 3.
        state = 8'h02;
        stream("st2", 598, 0, 4, 119600);
        pulse(1021);
        check("st2_en", mem_rd_en, 0);
        check("st2_busy", fetch_busy, 0);

        // Reset in the middle of a fetch.
        state = 8'h03;
        tick();
        pulse(1021);
        repeat (5) tick();
        check("rst_pre_en", mem_rd_en, 1);
        check("rst_pre_ur", underrun, 1);
        rst = 1'b1;
        tick();
        check_reset("rst1");
        tick();
        tick();
        check("rst3_busy", fetch_busy, 0);
        rst = 1'b0;
        tick();
        check("post_rst_en", mem_rd_en, 0);
        check("post_rst_busy", fetch_busy, 0);
        check("post_rst_ur", underrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
